// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- generator: FSM states, op encoding and the element table.
package mbist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_RD    = 3'd2,
      ST_RWAIT = 3'd3,
      ST_CHK   = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   // bit1 = read, bit0 = data background
   typedef enum logic [1:0] {
      OP_W0 = 2'd0,
      OP_W1 = 2'd1,
      OP_R0 = 2'd2,
      OP_R1 = 2'd3
   } op_e;

   localparam int NUM_ELEM = 6;

   // M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 dn(r0,w1); M4 dn(r1,w0); M5 up(r0)
   localparam logic [NUM_ELEM-1:0]   ELEM_UP      = 6'b100111;
   localparam logic [NUM_ELEM-1:0]   ELEM_TWO_OPS = 6'b011110;
   localparam logic [4*NUM_ELEM-1:0] ELEM_OPS     = 24'h236360;

   function automatic op_e march_op(input logic [2:0] elem, input logic op_idx);
      return op_e'(ELEM_OPS[{elem, op_idx, 1'b0} +: 2]);
   endfunction

   function automatic logic elem_is_up(input logic [2:0] elem);
      return ELEM_UP[elem];
   endfunction

   function automatic logic elem_last_op(input logic [2:0] elem, input logic op_idx);
      return ELEM_TWO_OPS[elem] ? op_idx : 1'b1;
   endfunction

   function automatic logic op_is_write(input op_e op);
      return ~op[1];
   endfunction

   function automatic logic op_data_bit(input op_e op);
      return op[0];
   endfunction

endpackage

// File: rtl/mbist_addr_counter.sv
// Up/down address counter for the march walk; is_last flags the terminal address of the current direction.
module mbist_addr_counter #(
   parameter int AW = 4
) (
   input  logic          comp_clk,
   input  logic          reset,
   input  logic          step,
   input  logic          dir_up,
   input  logic          load_zero,
   input  logic          load_max,
   output logic [AW-1:0] count,
   output logic          is_last
);

   always_ff @(posedge comp_clk) begin
      if (reset) begin
         count <= '0;
      end else if (load_zero) begin
         count <= '0;
      end else if (load_max) begin
         count <= '1;
      end else if (step) begin
         count <= dir_up ? count + AW'(1) : count - AW'(1);
      end
   end

   assign is_last = dir_up ? (count == '1) : (count == '0);

endmodule

// File: rtl/mbist_march_generator.sv
// March C- stimulus generator feeding an SRAM and the MBIST comparator.
// state    | meaning
// IDLE     | waiting for start (or a restart latched in DONE)
// WR       | one-cycle write of the current op
// RD       | one-cycle read strobe with capture
// RWAIT    | RD_LAT cycles of memory read latency
// CHK      | one-cycle comparator check strobe
// DONE     | algorithm complete, comp_alg_end held
module mbist_march_generator
   import mbist_pkg::*;
#(
   parameter int AW     = 4,
   parameter int DW     = 1,
   parameter int RD_LAT = 1
) (
   input  logic          comp_clk,
   input  logic          reset,
   input  logic          start,
   output logic [AW-1:0] mem_addr,
   output logic [DW:0]   mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   output logic [DW:0]   exp_data,
   output logic          capture,
   output logic          check,
   output logic          comp_en,
   output logic          comp_alg_end,
   output logic          busy,
   output logic [2:0]    elem_idx
);

   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_e          state_q, state_d;
   logic [2:0]      elem_q, elem_d;
   logic            op_q, op_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            pend_q, pend_d;
   logic            step, ld_zero, ld_max, launch, op_done;
   logic            addr_last;
   op_e             nxt_op;

   mbist_addr_counter #(.AW(AW)) u_addr (
      .comp_clk  (comp_clk),
      .reset     (reset),
      .step      (step),
      .dir_up    (elem_is_up(elem_q)),
      .load_zero (ld_zero),
      .load_max  (ld_max),
      .count     (mem_addr),
      .is_last   (addr_last)
   );

   always_ff @(posedge comp_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         elem_q  <= '0;
         op_q    <= 1'b0;
         wait_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         op_q    <= op_d;
         wait_q  <= wait_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      op_d    = op_q;
      wait_d  = wait_q;
      pend_d  = pend_q;
      step    = 1'b0;
      ld_zero = 1'b0;
      ld_max  = 1'b0;
      launch  = 1'b0;
      op_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start || pend_q) begin
               elem_d  = '0;
               op_d    = 1'b0;
               ld_zero = 1'b1;
               pend_d  = 1'b0;
               launch  = 1'b1;
            end
         end
         ST_WR:  op_done = 1'b1;
         ST_RD: begin
            state_d = ST_RWAIT;
            wait_d  = WW'(RD_LAT - 1);
         end
         ST_RWAIT: begin
            if (wait_q == '0) state_d = ST_CHK;
            else              wait_d  = wait_q - WW'(1);
         end
         ST_CHK: op_done = 1'b1;
         ST_DONE: begin
            // a restart request seen here must survive the IDLE cycle even if start drops
            if (start) begin
               state_d = ST_IDLE;
               pend_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (op_done) begin
         if (!elem_last_op(elem_q, op_q)) begin
            op_d   = 1'b1;
            launch = 1'b1;
         end else if (!addr_last) begin
            op_d   = 1'b0;
            step   = 1'b1;
            launch = 1'b1;
         end else if (elem_q == 3'(NUM_ELEM - 1)) begin
            state_d = ST_DONE;
         end else begin
            elem_d = elem_q + 3'd1;
            op_d   = 1'b0;
            launch = 1'b1;
            if (elem_is_up(elem_d)) ld_zero = 1'b1;
            else                    ld_max  = 1'b1;
         end
      end

      nxt_op = march_op(elem_d, op_d);
      if (launch) state_d = op_is_write(nxt_op) ? ST_WR : ST_RD;
   end

   always_ff @(posedge comp_clk) begin
      if (reset) begin
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         mem_re       <= 1'b0;
         exp_data     <= '0;
         capture      <= 1'b0;
         check        <= 1'b0;
         comp_en      <= 1'b0;
         comp_alg_end <= 1'b0;
         busy         <= 1'b0;
         elem_idx     <= '0;
      end else begin
         mem_we       <= (state_d == ST_WR);
         mem_re       <= (state_d == ST_RD);
         capture      <= (state_d == ST_RD);
         check        <= (state_d == ST_CHK);
         busy         <= (state_d != ST_IDLE) && (state_d != ST_DONE);
         comp_en      <= (state_d != ST_IDLE);
         comp_alg_end <= (state_d == ST_DONE);
         elem_idx     <= elem_d;
         if (state_d == ST_WR) mem_wdata <= {(DW+1){op_data_bit(nxt_op)}};
         if (state_d == ST_RD) exp_data  <= {(DW+1){op_data_bit(nxt_op)}};
      end
   end

endmodule

// File: tb/tb_mbist_march_generator.sv
// Directed bench for the March C- generator: trace vectors, run lengths, comparator model, reset and restart.
module tb_mbist_march_generator;

   logic comp_clk = 1'b0;
   logic reset    = 1'b1;
   logic start_a  = 1'b0;
   logic start_b  = 1'b0;

   logic [1:0] mem_addr_a, mem_wdata_a, exp_data_a;
   logic       mem_we_a, mem_re_a, capture_a, check_a, comp_en_a, comp_alg_end_a, busy_a;
   logic [2:0] elem_idx_a;

   logic [1:0] mem_addr_b, mem_wdata_b, exp_data_b;
   logic       mem_we_b, mem_re_b, capture_b, check_b, comp_en_b, comp_alg_end_b, busy_b;
   logic [2:0] elem_idx_b;

   always #5 comp_clk = ~comp_clk;

   mbist_march_generator #(.AW(2), .DW(1), .RD_LAT(1)) dut_a (
      .comp_clk(comp_clk), .reset(reset), .start(start_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .mem_re(mem_re_a),
      .exp_data(exp_data_a), .capture(capture_a), .check(check_a), .comp_en(comp_en_a),
      .comp_alg_end(comp_alg_end_a), .busy(busy_a), .elem_idx(elem_idx_a)
   );

   mbist_march_generator #(.AW(2), .DW(1), .RD_LAT(3)) dut_b (
      .comp_clk(comp_clk), .reset(reset), .start(start_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_re(mem_re_b),
      .exp_data(exp_data_b), .capture(capture_b), .check(check_b), .comp_en(comp_en_b),
      .comp_alg_end(comp_alg_end_b), .busy(busy_b), .elem_idx(elem_idx_b)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;

   int busy_cnt_a, we_cnt_a, chk_cnt_a, gap_bad_a, excl_bad, cap_cyc_a;
   int busy_cnt_b, chk_cnt_b, gap_bad_b, cap_cyc_b;
   bit cmp_fail_a, fault_en;
   logic [1:0] mem [4];
   logic [1:0] rd_val_a;
   logic [3:0] wr_q[$];
   logic [3:0] rd_q[$];

   typedef struct {
      string name;
      bit    is_wr;
      int    idx;
      int    addr;
      int    data;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge comp_clk);
         #1;
      end
   endtask

   always @(posedge comp_clk) cyc++;

   always @(negedge comp_clk) begin
      if (busy_a) busy_cnt_a++;
      if (mem_we_a) begin
         we_cnt_a++;
         wr_q.push_back({mem_addr_a, mem_wdata_a});
         mem[mem_addr_a] = mem_wdata_a;
      end
      if (mem_re_a) begin
         rd_q.push_back({mem_addr_a, exp_data_a});
         rd_val_a  = mem[mem_addr_a] | ((fault_en && mem_addr_a == 2'd2) ? 2'b01 : 2'b00);
         cap_cyc_a = cyc;
      end
      if (check_a) begin
         chk_cnt_a++;
         if (rd_val_a != exp_data_a) cmp_fail_a = 1'b1;
         if (cyc - cap_cyc_a != 2) gap_bad_a++;
      end
      if ((int'(mem_we_a) + int'(mem_re_a) + int'(check_a)) > 1 || capture_a != mem_re_a) excl_bad++;
      if (busy_b) busy_cnt_b++;
      if (mem_re_b) cap_cyc_b = cyc;
      if (check_b) begin
         chk_cnt_b++;
         if (cyc - cap_cyc_b != 4) gap_bad_b++;
      end
      if ((int'(mem_we_b) + int'(mem_re_b) + int'(check_b)) > 1 || capture_b != mem_re_b) excl_bad++;
   end

   task automatic clear_a();
      busy_cnt_a = 0; we_cnt_a = 0; chk_cnt_a = 0; gap_bad_a = 0; cmp_fail_a = 1'b0;
      wr_q.delete();
      rd_q.delete();
   endtask

   task automatic run_a(input string nm);
      int n;
      clear_a();
      start_a = 1'b1;
      n = 0;
      while (!busy_a && n < 10) begin tick(1); n++; end
      start_a = 1'b0;
      n = 0;
      while (!comp_alg_end_a && n < 400) begin tick(1); n++; end
      if (!comp_alg_end_a) chk({nm, " done timeout"}, 0, 1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 4; i++) mem[i] = 2'b00;
      fault_en = 1'b0;
      excl_bad = 0;
      busy_cnt_b = 0; chk_cnt_b = 0; gap_bad_b = 0;
      clear_a();

      vecs[0]  = '{"m0_wr0",   1'b1,  0, 0, 0};
      vecs[1]  = '{"m0_wr1",   1'b1,  1, 1, 0};
      vecs[2]  = '{"m0_wr2",   1'b1,  2, 2, 0};
      vecs[3]  = '{"m0_wr3",   1'b1,  3, 3, 0};
      vecs[4]  = '{"m1_rd0",   1'b0,  0, 0, 0};
      vecs[5]  = '{"m1_wr0",   1'b1,  4, 0, 3};
      vecs[6]  = '{"m2_rd0",   1'b0,  4, 0, 3};
      vecs[7]  = '{"m3_rd0",   1'b0,  8, 3, 0};
      vecs[8]  = '{"m3_wr0",   1'b1, 12, 3, 3};
      vecs[9]  = '{"m4_wr0",   1'b1, 16, 3, 0};
      vecs[10] = '{"m5_rdlast",1'b0, 19, 3, 0};

      tick(3);
      chk("rst_addr", int'(mem_addr_a), 0);
      chk("rst_strobes", int'({mem_we_a, mem_re_a, capture_a, check_a}), 0);
      chk("rst_ctrl", int'({comp_en_a, comp_alg_end_a, busy_a}), 0);
      chk("rst_data", int'({mem_wdata_a, exp_data_a}), 0);
      chk("rst_elem", int'(elem_idx_a), 0);
      reset = 1'b0;
      tick(2);
      chk("idle_no_start", int'(busy_a), 0);

      // ideal memory run
      run_a("run1");
      chk("run1_busy", busy_cnt_a, 80);
      chk("run1_we", we_cnt_a, 20);
      chk("run1_chk", chk_cnt_a, 20);
      chk("run1_gap", gap_bad_a, 0);
      chk("run1_cmp_fail", int'(cmp_fail_a), 0);
      chk("run1_comp_en", int'(comp_en_a), 1);
      chk("run1_elem", int'(elem_idx_a), 5);
      chk("run1_wr_n", wr_q.size(), 20);
      chk("run1_rd_n", rd_q.size(), 20);
      for (int i = 0; i < 11; i++) begin
         logic [3:0] e;
         if (vecs[i].is_wr) e = (vecs[i].idx < wr_q.size()) ? wr_q[vecs[i].idx] : 4'hx;
         else               e = (vecs[i].idx < rd_q.size()) ? rd_q[vecs[i].idx] : 4'hx;
         chk({vecs[i].name, "_addr"}, int'(e[3:2]), vecs[i].addr);
         chk({vecs[i].name, "_data"}, int'(e[1:0]), vecs[i].data);
      end
      tick(5);
      chk("run1_end_held", int'(comp_alg_end_a), 1);
      chk("run1_end_busy", int'(busy_a), 0);

      // stuck-at-1 bit 0 at addr 2
      fault_en = 1'b1;
      run_a("fault");
      chk("fault_cmp_fail", int'(cmp_fail_a), 1);
      chk("fault_done", int'(comp_alg_end_a), 1);
      chk("fault_busy", busy_cnt_a, 80);
      fault_en = 1'b0;

      // RD_LAT=3 instance
      start_b = 1'b1;
      tick(2);
      start_b = 1'b0;
      n = 0;
      while (!comp_alg_end_b && n < 400) begin tick(1); n++; end
      chk("lat3_done", int'(comp_alg_end_b), 1);
      chk("lat3_busy", busy_cnt_b, 120);
      chk("lat3_chk", chk_cnt_b, 20);
      chk("lat3_gap", gap_bad_b, 0);

      // reset in the middle of M2
      start_a = 1'b1;
      n = 0;
      while (elem_idx_a != 3'd2 && n < 200) begin tick(1); n++; end
      start_a = 1'b0;
      chk("mid_m2_reached", int'(elem_idx_a), 2);
      tick(3);
      reset = 1'b1;
      tick(1);
      chk("mid_rst_out", int'({mem_addr_a, mem_wdata_a, exp_data_a, mem_we_a, mem_re_a,
                               capture_a, check_a, comp_en_a, comp_alg_end_a, busy_a, elem_idx_a}), 0);
      reset = 1'b0;
      tick(3);
      chk("mid_rst_idle", int'({busy_a, comp_en_a}), 0);
      run_a("rerun");
      chk("rerun_busy", busy_cnt_a, 80);
      chk("rerun_first_wr", (wr_q.size() > 0) ? int'(wr_q[0]) : -1, 0);
      chk("rerun_first_rd", (rd_q.size() > 0) ? int'(rd_q[0]) : -1, 0);

      // start held high through DONE, then pulses while busy
      start_a = 1'b1;
      tick(1);
      chk("hold_gap1", int'({comp_alg_end_a, comp_en_a, busy_a}), 0);
      tick(1);
      chk("hold_run1_busy", int'(busy_a), 1);
      n = 0;
      while (!comp_alg_end_a && n < 200) begin tick(1); n++; end
      chk("hold_run1_done", int'(comp_alg_end_a), 1);
      tick(1);
      chk("hold_gap2", int'({comp_alg_end_a, comp_en_a, busy_a}), 0);
      clear_a();
      start_a = 1'b0;
      tick(1);
      chk("hold_run2_busy", int'(busy_a), 1);
      tick(10);
      start_a = 1'b1;
      tick(3);
      start_a = 1'b0;
      n = 0;
      while (!comp_alg_end_a && n < 200) begin tick(1); n++; end
      chk("hold_run2_done", int'(comp_alg_end_a), 1);
      chk("hold_run2_len", busy_cnt_a, 80);
      chk("hold_run2_we", we_cnt_a, 20);
      tick(3);
      chk("hold_no_restart", int'({comp_alg_end_a, busy_a}), 2);
      chk("strobe_exclusive", excl_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
